// File: rtl/psd_goertzel_avg.sv
// -----------------------------------------------------------------------------
// psd_goertzel_avg
//
// Single-bin power spectral density estimator. A Goertzel recursion runs over
// N-sample blocks of a signed input stream. The bin power of each block is
// computed and AVG block powers are averaged into one result word.
//
// Ports:
//   aclk       rising-edge clock
//   aresetn    asynchronous active-low reset
//   start      begin a measurement (honoured only while idle)
//   abort      synchronous return to idle from any state
//   cfg_coeff  c = 2cos(2*pi*k/N), signed Q3.(K_W-3), latched on accepted start
//   s_valid    input sample valid
//   s_ready    input sample accepted when s_valid && s_ready
//   s_data     signed input sample
//   m_valid    averaged result valid
//   m_ready    result accepted when m_valid && m_ready
//   m_data     averaged bin power (unsigned)
//   busy       measurement in progress (state != IDLE)
//   overflow   sticky: a state-register add overflowed during this measurement
// -----------------------------------------------------------------------------
module psd_goertzel_avg #(
    parameter int W     = 16,
    parameter int N     = 256,
    parameter int AVG   = 4,
    parameter int K_W   = 18,
    parameter int ACC_W = 40,
    parameter int P_W   = 2*ACC_W
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic signed [K_W-1:0] cfg_coeff,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [W-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [P_W-1:0]        m_data,
    output logic                  busy,
    output logic                  overflow
);

    localparam int F      = K_W - 3;
    localparam int AVG_SH = (AVG > 1) ? $clog2(AVG) : 0;
    localparam int CNT_W  = $clog2(N);
    localparam int BLK_W  = (AVG > 1) ? $clog2(AVG) : 1;
    localparam int PA_W   = P_W + AVG_SH;
    localparam int KA_W   = K_W + ACC_W;
    localparam int SUM_W  = KA_W + 1;
    localparam int PR_W   = 2 * ACC_W;
    localparam int PS_W   = PR_W + 2;

    typedef enum logic [2:0] {IDLE, RUN, P1, P2, OUT} state_t;

    // Negative block power (possible only through rounding of c*s1) is clamped to 0.
    function automatic logic [P_W-1:0] clamp_pos(input logic signed [PS_W-1:0] v);
        if (v[PS_W-1])
            return '0;
        return P_W'($unsigned(v));
    endfunction

    state_t                   state_q;
    logic signed [K_W-1:0]    c_q;
    logic signed [ACC_W-1:0]  s1_q, s2_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [BLK_W-1:0]         blk_q;
    logic [PA_W-1:0]          acc_q;
    logic signed [PR_W-1:0]   a_q, b_q, t_q;
    logic                     ovf_q;
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic [P_W-1:0]           m_data_q;

    // Recursion term (c*s1) >>> F, kept at full width so the add can be
    // checked exactly for overflow of the ACC_W state register.
    logic signed [KA_W-1:0]   c_x, s1_x, cs1_full;
    logic signed [SUM_W-1:0]  x_s, cs1_s, s2_s, sum_d;
    logic signed [ACC_W-1:0]  s1_d;
    logic                     add_ovf;

    assign c_x      = {{ACC_W{c_q[K_W-1]}}, c_q};
    assign s1_x     = {{K_W{s1_q[ACC_W-1]}}, s1_q};
    assign cs1_full = (c_x * s1_x) >>> F;

    assign x_s      = {{(SUM_W-W){s_data[W-1]}}, s_data};
    assign cs1_s    = {cs1_full[KA_W-1], cs1_full};
    assign s2_s     = {{(SUM_W-ACC_W){s2_q[ACC_W-1]}}, s2_q};
    assign sum_d    = x_s + cs1_s - s2_s;
    assign s1_d     = sum_d[ACC_W-1:0];
    assign add_ovf  = (sum_d != {{(SUM_W-ACC_W){sum_d[ACC_W-1]}}, sum_d[ACC_W-1:0]});

    // Power products, all in 2*ACC_W signed.
    logic signed [PR_W-1:0]   s1_p, s2_p, cs1_p, a_d, b_d, t_d;
    logic signed [PS_W-1:0]   p_sum;
    logic [P_W-1:0]           p_u;

    assign s1_p  = {{ACC_W{s1_q[ACC_W-1]}}, s1_q};
    assign s2_p  = {{ACC_W{s2_q[ACC_W-1]}}, s2_q};
    assign cs1_p = {{ACC_W{cs1_full[ACC_W-1]}}, cs1_full[ACC_W-1:0]};
    assign a_d   = s1_p * s1_p;
    assign b_d   = s2_p * s2_p;
    assign t_d   = cs1_p * s2_p;

    assign p_sum = {{2{a_q[PR_W-1]}}, a_q} + {{2{b_q[PR_W-1]}}, b_q} - {{2{t_q[PR_W-1]}}, t_q};
    assign p_u   = clamp_pos(p_sum);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            c_q       <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            blk_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= '0;
            ovf_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (abort) begin
            // Accumulators and overflow are left intact for inspection.
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        c_q       <= cfg_coeff;
                        s1_q      <= '0;
                        s2_q      <= '0;
                        cnt_q     <= '0;
                        blk_q     <= '0;
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (s_valid && s_ready_q) begin
                        s1_q <= s1_d;
                        s2_q <= s1_q;
                        if (add_ovf)
                            ovf_q <= 1'b1;
                        if (cnt_q == CNT_W'(N-1)) begin
                            state_q   <= P1;
                            s_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                P1: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    t_q     <= t_d;
                    state_q <= P2;
                end
                P2: begin
                    acc_q <= acc_q + PA_W'(p_u);
                    s1_q  <= '0;
                    s2_q  <= '0;
                    cnt_q <= '0;
                    if (blk_q == BLK_W'(AVG-1)) begin
                        state_q <= OUT;
                    end else begin
                        blk_q     <= blk_q + BLK_W'(1);
                        state_q   <= RUN;
                        s_ready_q <= 1'b1;
                    end
                end
                OUT: begin
                    // First OUT cycle registers the averaged word; it is then
                    // held until the consumer takes it.
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= P_W'(acc_q >> AVG_SH);
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_psd_goertzel_avg.sv
// -----------------------------------------------------------------------------
// tb_psd_goertzel_avg
//
// Three instances of psd_goertzel_avg exercised one at a time:
//   inst 0: N=4,   AVG=1, ACC_W=40
//   inst 1: N=4,   AVG=2, ACC_W=40
//   inst 2: N=256, AVG=1, ACC_W=20
// Expected results are queued by the stimulus; a monitor pops and compares
// whenever any instance hands over a result.
// -----------------------------------------------------------------------------
module tb_psd_goertzel_avg;

    logic aclk;
    logic aresetn;

    logic               start_r   [3];
    logic               abort_r   [3];
    logic signed [17:0] coeff_r   [3];
    logic               s_valid_r [3];
    logic signed [15:0] s_data_r  [3];
    logic               m_ready_r [3];

    logic s_ready_w [3];
    logic m_valid_w [3];
    logic busy_w    [3];
    logic ovf_w     [3];

    logic [79:0] md0, md1;
    logic [39:0] md2;
    logic [79:0] md [3];

    assign md[0] = md0;
    assign md[1] = md1;
    assign md[2] = {40'b0, md2};

    int total = 0;
    int bad   = 0;
    logic [79:0] expq [$];

    psd_goertzel_avg #(.W(16), .N(4), .AVG(1), .K_W(18), .ACC_W(40)) u0 (
        .aclk(aclk), .aresetn(aresetn), .start(start_r[0]), .abort(abort_r[0]),
        .cfg_coeff(coeff_r[0]), .s_valid(s_valid_r[0]), .s_ready(s_ready_w[0]),
        .s_data(s_data_r[0]), .m_valid(m_valid_w[0]), .m_ready(m_ready_r[0]),
        .m_data(md0), .busy(busy_w[0]), .overflow(ovf_w[0]));

    psd_goertzel_avg #(.W(16), .N(4), .AVG(2), .K_W(18), .ACC_W(40)) u1 (
        .aclk(aclk), .aresetn(aresetn), .start(start_r[1]), .abort(abort_r[1]),
        .cfg_coeff(coeff_r[1]), .s_valid(s_valid_r[1]), .s_ready(s_ready_w[1]),
        .s_data(s_data_r[1]), .m_valid(m_valid_w[1]), .m_ready(m_ready_r[1]),
        .m_data(md1), .busy(busy_w[1]), .overflow(ovf_w[1]));

    psd_goertzel_avg #(.W(16), .N(256), .AVG(1), .K_W(18), .ACC_W(20)) u2 (
        .aclk(aclk), .aresetn(aresetn), .start(start_r[2]), .abort(abort_r[2]),
        .cfg_coeff(coeff_r[2]), .s_valid(s_valid_r[2]), .s_ready(s_ready_w[2]),
        .s_data(s_data_r[2]), .m_valid(m_valid_w[2]), .m_ready(m_ready_r[2]),
        .m_data(md2), .busy(busy_w[2]), .overflow(ovf_w[2]));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] sx40(input logic [39:0] v);
        return {{40{v[39]}}, v};
    endfunction

    // Scoreboard monitor: any handed-over result must match the queue head.
    always @(negedge aclk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_valid_w[i] && m_ready_r[i]) begin
                if (expq.size() == 0) begin
                    chk($sformatf("unexpected_result_inst%0d", i), md[i], 80'hFFFF);
                end else begin
                    logic [79:0] e;
                    e = expq.pop_front();
                    chk($sformatf("m_data_inst%0d", i), md[i], e);
                end
            end
        end
    end

    task automatic do_start(input int i, input logic signed [17:0] c);
        @(negedge aclk);
        coeff_r[i] = c;
        start_r[i] = 1'b1;
        @(posedge aclk);
        #1 start_r[i] = 1'b0;
    endtask

    task automatic do_abort(input int i);
        @(negedge aclk);
        abort_r[i] = 1'b1;
        @(posedge aclk);
        #1 abort_r[i] = 1'b0;
    endtask

    // Present one sample and hold it until accepted; returns stall cycles seen.
    task automatic send(input int i, input int x, output int waited);
        waited = 0;
        @(negedge aclk);
        s_data_r[i]  = 16'(x);
        s_valid_r[i] = 1'b1;
        while (!s_ready_w[i] && waited < 50) begin
            @(negedge aclk);
            waited++;
        end
        if (waited >= 50) begin
            chk("send_timeout", 80'(waited), 80'd0);
        end else begin
            @(posedge aclk);
        end
        #1 s_valid_r[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((busy_w[i] || expq.size() != 0) && n < 100) begin
            @(posedge aclk);
            #1 n++;
        end
        chk("idle_timeout", 80'(n < 100), 80'd1);
    endtask

    initial begin
        int w;
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_r[i]   = 1'b0;
            abort_r[i]   = 1'b0;
            coeff_r[i]   = '0;
            s_valid_r[i] = 1'b0;
            s_data_r[i]  = '0;
            m_ready_r[i] = 1'b1;
        end
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_s_ready", 80'(s_ready_w[0]), 80'd0);
        chk("rst_m_valid", 80'(m_valid_w[0]), 80'd0);
        chk("rst_busy",    80'(busy_w[0]),    80'd0);
        chk("rst_ovf",     80'(ovf_w[0]),     80'd0);
        chk("rst_m_data",  md[0],             80'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Tone bin, c=0: samples 1,0,-1,0 -> s1=0, s2=-2, power 4.
        expq.push_back(80'd4);
        do_start(0, 18'sd0);
        send(0, 1, w); send(0, 0, w); send(0, -1, w); send(0, 0, w);
        chk("tone_s1", sx40(u0.s1_q), 80'd0);
        chk("tone_s2", sx40(u0.s2_q), 80'(-2));
        lat = 0;
        while (!m_valid_w[0] && lat < 20) begin
            @(posedge aclk);
            #1 lat++;
        end
        chk("tone_latency", 80'(lat), 80'd3);
        chk("tone_ovf", 80'(ovf_w[0]), 80'd0);
        wait_idle(0);

        // DC bin, c=2.0: four 1s -> s1=10, s2=6, power 16.
        expq.push_back(80'd16);
        do_start(0, 18'sd65536);
        for (int k = 0; k < 4; k++) send(0, 1, w);
        chk("dc_s1", sx40(u0.s1_q), 80'd10);
        chk("dc_s2", sx40(u0.s2_q), 80'd6);
        wait_idle(0);

        // Averaging over two blocks: powers 16 and 144 -> 80.
        expq.push_back(80'd80);
        do_start(1, 18'sd65536);
        for (int k = 0; k < 4; k++) send(1, 1, w);
        send(1, 3, w);
        chk("avg_gap_cycles", 80'(w), 80'd2);
        for (int k = 0; k < 3; k++) send(1, 3, w);
        wait_idle(1);

        // Backpressure: result held, start ignored, then released.
        m_ready_r[0] = 1'b0;
        do_start(0, 18'sd65536);
        for (int k = 0; k < 4; k++) send(0, 1, w);
        lat = 0;
        while (!m_valid_w[0] && lat < 20) begin
            @(posedge aclk);
            #1 lat++;
        end
        for (int k = 0; k < 10; k++) begin
            coeff_r[0] = 18'sd0;
            start_r[0] = k[0];
            @(posedge aclk);
            #1;
            chk("bp_m_valid", 80'(m_valid_w[0]), 80'd1);
            chk("bp_m_data",  md[0],             80'd16);
            chk("bp_s_ready", 80'(s_ready_w[0]), 80'd0);
        end
        start_r[0] = 1'b0;
        expq.push_back(80'd16);
        m_ready_r[0] = 1'b1;
        @(posedge aclk);
        #1;
        chk("bp_busy_after", 80'(busy_w[0]), 80'd0);
        chk("bp_valid_after", 80'(m_valid_w[0]), 80'd0);

        // Start and abort together in IDLE: abort wins.
        @(negedge aclk);
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        @(posedge aclk);
        #1;
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        chk("start_abort_busy", 80'(busy_w[0]), 80'd0);

        // Abort after two samples, then a clean tone measurement.
        do_start(0, 18'sd65536);
        send(0, 1, w); send(0, 1, w);
        do_abort(0);
        chk("abort_busy",    80'(busy_w[0]),    80'd0);
        chk("abort_s_ready", 80'(s_ready_w[0]), 80'd0);
        repeat (5) @(posedge aclk);
        #1 chk("abort_no_valid", 80'(m_valid_w[0]), 80'd0);
        expq.push_back(80'd4);
        do_start(0, 18'sd0);
        send(0, 1, w); send(0, 0, w); send(0, -1, w); send(0, 0, w);
        wait_idle(0);

        // Overflow on the narrow instance: DC 32767 with c=2.0 wraps on sample 6.
        do_start(2, 18'sd65536);
        for (int k = 0; k < 5; k++) send(2, 32767, w);
        chk("ovf_before", 80'(ovf_w[2]), 80'd0);
        send(2, 32767, w);
        chk("ovf_set", 80'(ovf_w[2]), 80'd1);
        send(2, 0, w); send(2, 0, w);
        chk("ovf_sticky", 80'(ovf_w[2]), 80'd1);
        do_abort(2);
        repeat (3) @(posedge aclk);
        #1 chk("ovf_kept_idle", 80'(ovf_w[2]), 80'd1);
        do_start(2, 18'sd0);
        chk("ovf_cleared", 80'(ovf_w[2]), 80'd0);
        do_abort(2);

        // Asynchronous reset while in P1 discards the pending result.
        do_start(0, 18'sd65536);
        for (int k = 0; k < 4; k++) send(0, 1, w);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_busy",    80'(busy_w[0]),    80'd0);
        chk("arst_m_valid", 80'(m_valid_w[0]), 80'd0);
        chk("arst_s_ready", 80'(s_ready_w[0]), 80'd0);
        chk("arst_m_data",  md[0],             80'd0);
        chk("arst_ovf",     80'(ovf_w[0]),     80'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
        chk("arst_no_result", 80'(m_valid_w[0]), 80'd0);
        chk("queue_empty", 80'(expq.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/psd_goertzel_avg.md
Name: psd_goertzel_avg

Overview:
- Single-bin power spectral density estimator for delta-control test and measurement paths.
- Runs a Goertzel recursion over N-sample blocks of a signed input stream, for example a decimated delta-sigma bitstream.
- Computes per-block bin power and averages AVG blocks.
- Presents one averaged power word on a valid/ready output.
- Generalises the fixed tb_psd spectral check into a parametrised, reusable RTL block.

Parameters:
- W, 16: signed input sample width.
- N, 256: samples per block; must be ≥ 2.
- AVG, 4: blocks averaged per result; must be a power of 2, ≥ 1.
- K_W, 18: coefficient width, signed Q3.(K_W-3); F = K_W-3 fractional bits.
- ACC_W, 40: signed Goertzel state register width.
- P_W, 2*ACC_W: output power width (unsigned).

Ports:
- aclk  in  1  clock, rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  begin measurement; honoured only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- cfg_coeff  in  K_W  c = 2cos(2πk/N), signed Q3.F; latched on accepted start.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid && s_ready.
- s_data  in  W  signed sample.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted when m_valid && m_ready.
- m_data  out  P_W  averaged bin power.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; state-register add overflowed during the current measurement.

Behaviour:
- Reset (aresetn low, async): state=IDLE; all registers 0; s_ready=0, m_valid=0, m_data=0, busy=0, overflow=0.
- States: IDLE, RUN, P1, P2, OUT.
- IDLE:
  - start=1 → RUN.
  - On entry to RUN: latch cfg_coeff; clear s1, s2, sample count, block count, power accumulator and overflow.
- RUN:
  - s_ready=1.
  - Per accepted sample: s1 ← x + ((c*s1) >>> F) − s2, and s2 ← s1.
  - Arithmetic shift, i.e. floor; x is sign-extended.
  - If the signed ACC_W add overflows (sign check), set overflow; the value wraps.
  - The Nth accepted sample of a block → P1.
- P1 (s_ready=0): register a=s1*s1, b=s2*s2, t=((c*s1)>>>F)*s2, each 2*ACC_W signed.
- P2:
  - p = a + b − t.
  - If p < 0, clamp to 0.
  - Power accumulator += p; the accumulator is P_W+log2(AVG) wide.
  - Clear s1, s2 and the sample count.
  - If block count == AVG−1 → OUT; else block count++ and → RUN.
- OUT:
  - m_valid=1; m_data = accumulator >> log2(AVG), truncated, held stable.
  - m_valid && m_ready → IDLE, and m_valid drops on the next cycle.
- Latency: m_valid rises 3 cycles after the edge that accepts the final sample.
- Between blocks there are 2 idle cycles (P1, P2) with s_ready=0.
- start outside IDLE is ignored, and cfg_coeff is not re-latched.
- abort has priority over every transition:
  - next state IDLE; m_valid=0; s_ready=0.
  - Accumulators and overflow are kept for inspection until the next start.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Reset mid-operation: immediate IDLE; any pending result is discarded.
- AVG=1: the shift is 0 and the result equals the single-block power.
- The sample counter wraps exactly at N, with no off-by-one.
- The block counter wraps exactly at AVG.

Test Plan:
- Tone bin, N=4, AVG=1, c=0, samples 1,0,−1,0 → state ends at s1=0, s2=−2; m_data=4 exactly 3 cycles after the 4th sample; overflow=0.
- DC bin, N=4, AVG=1, c=65536 (2.0), samples 1,1,1,1 → s1=10, s2=6; m_data=16.
- Averaging, N=4, AVG=2, c=65536:
  - block 1 all 1s, block 2 all 3s → block powers 16 and 144; m_data=80.
  - s_ready low for exactly 2 cycles between blocks.
- Backpressure:
  - hold m_ready=0 for 10 cycles → m_valid and m_data stable; start pulses ignored; s_ready=0.
  - m_ready=1 → IDLE; busy=0 next cycle.
- Abort/reset:
  - abort after 2 samples → IDLE, no m_valid; a new start with different c yields a clean correct result.
  - aresetn low mid-P1 → all outputs 0 asynchronously.
- Overflow: ACC_W=20, c=65536, N=256, x=32767 constant → overflow=1 sticky until the next accepted start.
